// File: rtl/serial_full_adder_using_multiplexer8x1_if.sv
// Request/result bundle for the bit-serial mux-based adder.
//   start     master->slave  request, sampled only while the engine is idle
//   a, b      master->slave  operands, captured when start is accepted
//   cin       master->slave  carry-in, captured when start is accepted
//   busy      slave->master  engine is running or presenting a result
//   done      slave->master  one-cycle pulse: sum/cout/overflow valid
//   sum       slave->master  a + b + cin, low WIDTH bits
//   cout      slave->master  carry out of the MSB
//   overflow  slave->master  signed overflow (carry into MSB ^ carry out of MSB)
interface serial_full_adder_using_multiplexer8x1_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_full_adder_using_multiplexer8x1.sv
// Bit-serial WIDTH-bit adder. Each bit's full-adder function is evaluated as
// an 8:1 multiplexer lookup with select {a_bit, b_bit, carry}. Operands are
// captured on start and consumed LSB-first, one bit per clock; the result is
// presented for one cycle with done and then held until the next accepted start.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts an operation in flight)
//   bus    slave side of serial_full_adder_using_multiplexer8x1_if
module serial_full_adder_using_multiplexer8x1 #(
  parameter int unsigned WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  serial_full_adder_using_multiplexer8x1_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Truth-table data for the two multiplexers, indexed by {a, b, carry}.
  localparam logic [7:0] MUX_SUM   = 8'b1001_0110;
  localparam logic [7:0] MUX_CARRY = 8'b1110_1000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_q;
  logic             c, cout_q, ovf_q;
  logic [CW-1:0]    cnt;
  logic [2:0]       sel;
  logic             s, k, last;
  logic [WIDTH:0]   sum_shift;

  assign sel       = {a_sr[0], b_sr[0], c};
  assign s         = MUX_SUM[sel];
  assign k         = MUX_CARRY[sel];
  assign last      = (cnt == LAST);
  // New sum bit enters at the MSB; taking the upper WIDTH bits of this
  // concatenation also works for WIDTH=1, where a part-select would be empty.
  assign sum_shift = {s, sum_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      sum_q  <= '0;
      c      <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            c      <= bus.cin;
            cnt    <= '0;
            sum_sr <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
          end
        end
        RUN: begin
          sum_sr <= sum_shift[WIDTH:1];
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          c      <= k;
          if (last) begin
            // c is still the carry into the MSB here; k is the carry out.
            sum_q  <= sum_shift[WIDTH:1];
            cout_q <= k;
            ovf_q  <= c ^ k;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule
